// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm -- multi-cycle MIPS-subset control unit.
//
// Steps each instruction through IF/ID/EXE/MEM/WB. It decodes opcode/funct
// into datapath controls and counts the legal instructions it retires.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   opcode, funct    Inst[31:26] and Inst[5:0] from the instruction register
//   ZF, SF           ALU zero / sign flags, sampled in EXE for branches
//   PCWr, IRWr       PC and IR load enables
//   ALUSrcA/B        ALU operand selects (shamt / extended immediate)
//   DataSrc, RegDst  write-back data select and destination register select
//   ExtSel           immediate extension (1 = sign)
//   RegWr, MemRd, MemWr  register-file and data-memory strobes
//   PCSrc            next-PC select (00 PC+4, 01 branch, 10 jump)
//   ALUCtrl          ALU operation
//   Illegal          one-cycle pulse in ID for an unknown opcode/funct
//   State            current FSM state
//   InstCnt          retired legal instruction count (wraps)
module mc_ctrl_fsm #(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        ZF,
  input  logic        SF,
  output logic        PCWr,
  output logic        IRWr,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic        DataSrc,
  output logic        RegWr,
  output logic        MemRd,
  output logic        MemWr,
  output logic        RegDst,
  output logic        ExtSel,
  output logic [1:0]  PCSrc,
  output logic [3:0]  ALUCtrl,
  output logic        Illegal,
  output logic [2:0]  State,
  output logic [15:0] InstCnt
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_t;

  typedef enum logic [2:0] {
    K_ALU  = 3'd0,
    K_LW   = 3'd1,
    K_SW   = 3'd2,
    K_BR   = 3'd3,
    K_J    = 3'd4,
    K_HALT = 3'd5,
    K_ILL  = 3'd6
  } kind_t;

  state_t      state_q, state_d;
  logic [15:0] inst_cnt_q, inst_cnt_d;

  kind_t       kind_s;
  logic [3:0]  alu_s;
  logic        src_a_s, src_b_s, data_src_s, reg_dst_s, ext_sel_s, br_take_s;

  logic        pcwr_s, irwr_s, regwr_s, memrd_s, memwr_s, illegal_s, stat_en_s;
  logic [1:0]  pcsrc_s;

  // Instruction decode: instruction class, static datapath controls, branch condition.
  always_comb begin
    kind_s     = K_ILL;
    alu_s      = 4'b0000;
    src_a_s    = 1'b0;
    src_b_s    = 1'b0;
    data_src_s = 1'b0;
    reg_dst_s  = 1'b0;
    ext_sel_s  = 1'b0;
    br_take_s  = 1'b0;
    if (opcode == HALT_OP) begin
      kind_s = K_HALT;
    end else begin
      case (opcode)
        6'b000000: begin
          kind_s    = K_ALU;
          reg_dst_s = 1'b1;
          case (funct)
            6'b100000: alu_s = 4'b0100;                         // add
            6'b100001: alu_s = 4'b0101;                         // addu
            6'b100010: alu_s = 4'b0110;                         // sub
            6'b100100: alu_s = 4'b0000;                         // and
            6'b100101: alu_s = 4'b0001;                         // or
            6'b100110: alu_s = 4'b1010;                         // xor
            6'b100111: alu_s = 4'b0011;                         // nor
            6'b101010: alu_s = 4'b1001;                         // slt
            6'b101011: alu_s = 4'b1000;                         // sltu
            6'b000000: begin alu_s = 4'b0010; src_a_s = 1'b1; end  // sll
            6'b000010: begin alu_s = 4'b0111; src_a_s = 1'b1; end  // srl
            6'b000100: alu_s = 4'b0010;                         // sllv
            6'b000110: alu_s = 4'b0111;                         // srlv
            default: begin
              kind_s    = K_ILL;
              reg_dst_s = 1'b0;
            end
          endcase
        end
        6'b001000: begin kind_s = K_ALU; alu_s = 4'b0100; src_b_s = 1'b1; ext_sel_s = 1'b1; end // addi
        6'b001001: begin kind_s = K_ALU; alu_s = 4'b0101; src_b_s = 1'b1; ext_sel_s = 1'b1; end // addiu
        6'b001010: begin kind_s = K_ALU; alu_s = 4'b1001; src_b_s = 1'b1; ext_sel_s = 1'b1; end // slti
        6'b001011: begin kind_s = K_ALU; alu_s = 4'b1000; src_b_s = 1'b1; ext_sel_s = 1'b1; end // sltiu
        6'b001100: begin kind_s = K_ALU; alu_s = 4'b0000; src_b_s = 1'b1; end                   // andi
        6'b001101: begin kind_s = K_ALU; alu_s = 4'b0001; src_b_s = 1'b1; end                   // ori
        6'b001110: begin kind_s = K_ALU; alu_s = 4'b1010; src_b_s = 1'b1; ext_sel_s = 1'b1; end // xori
        6'b100011: begin kind_s = K_LW; alu_s = 4'b0100; src_b_s = 1'b1; ext_sel_s = 1'b1; data_src_s = 1'b1; end
        6'b101011: begin kind_s = K_SW; alu_s = 4'b0100; src_b_s = 1'b1; ext_sel_s = 1'b1; end
        // Branches compare Rs/Rt; the offset is sign-extended for the target adder.
        6'b000100: begin kind_s = K_BR; alu_s = 4'b0110; ext_sel_s = 1'b1; br_take_s = ZF; end        // beq
        6'b000101: begin kind_s = K_BR; alu_s = 4'b0110; ext_sel_s = 1'b1; br_take_s = ~ZF; end       // bne
        6'b000001: begin kind_s = K_BR; alu_s = 4'b0100; ext_sel_s = 1'b1; br_take_s = SF; end        // bltz
        6'b000111: begin kind_s = K_BR; alu_s = 4'b0100; ext_sel_s = 1'b1; br_take_s = ~SF & ~ZF; end // bgtz
        6'b000110: begin kind_s = K_BR; alu_s = 4'b0100; ext_sel_s = 1'b1; br_take_s = SF | ZF; end   // blez
        6'b000010: kind_s = K_J;
        default:   kind_s = K_ILL;
      endcase
    end
  end

  // Next-state and strobe generation; the count advances on every legal retire.
  always_comb begin
    state_d    = state_q;
    inst_cnt_d = inst_cnt_q;
    pcwr_s     = 1'b0;
    irwr_s     = 1'b0;
    regwr_s    = 1'b0;
    memrd_s    = 1'b0;
    memwr_s    = 1'b0;
    illegal_s  = 1'b0;
    stat_en_s  = 1'b0;
    pcsrc_s    = 2'b00;
    case (state_q)
      S_IF: begin
        irwr_s  = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        stat_en_s = 1'b1;
        case (kind_s)
          K_J:    begin pcwr_s = 1'b1; pcsrc_s = 2'b10; state_d = S_IF; end
          K_HALT: state_d = S_HALT;
          K_ILL:  begin pcwr_s = 1'b1; illegal_s = 1'b1; state_d = S_IF; end
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        stat_en_s = 1'b1;
        case (kind_s)
          K_BR: begin
            pcwr_s  = 1'b1;
            pcsrc_s = br_take_s ? 2'b01 : 2'b00;
            state_d = S_IF;
          end
          K_LW, K_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        stat_en_s = 1'b1;
        if (kind_s == K_SW) begin
          memwr_s = 1'b1;
          pcwr_s  = 1'b1;
          state_d = S_IF;
        end else begin
          memrd_s = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB: begin
        stat_en_s = 1'b1;
        regwr_s   = 1'b1;
        pcwr_s    = 1'b1;
        // lw keeps the read asserted so memory data stays valid for the write.
        memrd_s   = (kind_s == K_LW);
        state_d   = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
    if (pcwr_s && !illegal_s) begin
      inst_cnt_d = inst_cnt_q + 16'd1;
    end else begin
      inst_cnt_d = inst_cnt_q;
    end
  end

  // State and retire-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IF;
      inst_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      inst_cnt_q <= inst_cnt_d;
    end
  end

  // Output drive; gated by rst_n so any in-flight write strobe drops the moment reset asserts.
  always_comb begin
    if (rst_n) begin
      PCWr    = pcwr_s;
      IRWr    = irwr_s;
      ALUSrcA = stat_en_s & src_a_s;
      ALUSrcB = stat_en_s & src_b_s;
      DataSrc = stat_en_s & data_src_s;
      RegWr   = regwr_s;
      MemRd   = memrd_s;
      MemWr   = memwr_s;
      RegDst  = stat_en_s & reg_dst_s;
      ExtSel  = stat_en_s & ext_sel_s;
      PCSrc   = pcsrc_s;
      ALUCtrl = stat_en_s ? alu_s : 4'b0000;
      Illegal = illegal_s;
      State   = state_q;
      InstCnt = inst_cnt_q;
    end else begin
      PCWr    = 1'b0;
      IRWr    = 1'b0;
      ALUSrcA = 1'b0;
      ALUSrcB = 1'b0;
      DataSrc = 1'b0;
      RegWr   = 1'b0;
      MemRd   = 1'b0;
      MemWr   = 1'b0;
      RegDst  = 1'b0;
      ExtSel  = 1'b0;
      PCSrc   = 2'b00;
      ALUCtrl = 4'b0000;
      Illegal = 1'b0;
      State   = 3'b000;
      InstCnt = 16'd0;
    end
  end

endmodule
